router_ctrl_fsm: RTL and testbench
==================================

// Module: router_ctrl_fsm
// PURPOSE
//  Packet-sequencing controller for the 1x3 router.
//  - Watches the source-side stream (pkt_valid, header byte on data_in) and the per-destination FIFO status.
//  - Drives the load/hold strobes for the input register block and FIFO write enables.
//  - Drives busy back to the source interface.
//  - Sits between the source interface and the register, synchronizer and FIFO blocks.
//  - One packet is handled at a time.
// PARAMETERS
//  NUM_DEST  3  number of destination FIFOs; address NUM_DEST..3 is invalid
//  ADDR_W    2  width of header destination field, data_in[ADDR_W-1:0]
// PORTS
//  clock          in   1        system clock; all logic on posedge
//  resetn         in   1        synchronous, active-low reset
//  pkt_valid      in   1        source packet-valid, high from header through last payload byte
//  data_in        in   ADDR_W   header dest field (data_in[1:0] of source byte)
//  fifo_full      in   1        selected-destination FIFO full (from synchronizer)
//  fifo_empty     in   NUM_DEST per-destination FIFO empty
//  soft_reset     in   NUM_DEST per-destination read-timeout soft reset
//  parity_done    in   1        register block has captured parity byte
//  low_pkt_valid  in   1        register block saw pkt_valid fall while FIFO full
//  dest_addr      out  ADDR_W   destination latched at header accept
//  detect_add     out  1        header-decode state indicator
//  lfd_state      out  1        load-first-data (header write) strobe
//  ld_state       out  1        load-payload strobe
//  laf_state      out  1        load-after-full strobe
//  full_state     out  1        FIFO-full hold indicator
//  rst_int_reg    out  1        clear internal parity/error registers
//  write_enb_reg  out  1        FIFO write enable
//  busy           out  1        stall source; source holds data_in while high
// BEHAVIOUR
//  - Single binary state register; outputs are Moore decodes of state.
//  - Output change is visible in the same cycle as the state.
//  - Reset (resetn=0 at posedge): state=DECODE_ADDRESS and dest_addr=0.
//    Outputs then: detect_add=1; all other outputs 0; busy=0.
//  - dest_addr loads data_in when state=DECODE_ADDRESS & pkt_valid & data_in<NUM_DEST.
//    dest_addr holds otherwise.
//  - Soft-reset priority: soft_reset[dest_addr]=1 in any state except DECODE_ADDRESS -> DECODE_ADDRESS next cycle.
//    This overrides all other transitions. resetn has higher priority still.
//  States (outputs asserted; others 0):
//   DECODE_ADDRESS  detect_add; busy=0
//     - pkt_valid & addr valid & fifo_empty[addr]  -> LOAD_FIRST_DATA
//     - pkt_valid & addr valid & !fifo_empty[addr] -> WAIT_TILL_EMPTY
//     - addr invalid, or !pkt_valid                -> stay; packet dropped, no write
//   LOAD_FIRST_DATA  lfd_state, busy -> LOAD_DATA (always, 1 cycle)
//   LOAD_DATA  ld_state, write_enb_reg; busy=0
//     - fifo_full  -> FIFO_FULL_STATE (fifo_full has priority over pkt_valid)
//     - !pkt_valid -> LOAD_PARITY
//     - else stay
//   FIFO_FULL_STATE  full_state, busy; no write
//     - !fifo_full -> LOAD_AFTER_FULL; else stay
//   LOAD_AFTER_FULL  laf_state, write_enb_reg, busy
//     - parity_done                 -> DECODE_ADDRESS
//     - !parity_done & low_pkt_valid  -> LOAD_PARITY
//     - !parity_done & !low_pkt_valid -> LOAD_DATA
//   LOAD_PARITY  write_enb_reg, busy -> CHECK_PARITY_ERROR (always)
//   CHECK_PARITY_ERROR  rst_int_reg, busy
//     - fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS
//   WAIT_TILL_EMPTY  busy; no write
//     - fifo_empty[dest_addr] -> LOAD_FIRST_DATA; else stay
//  - Latency: header accepted in DECODE_ADDRESS; header written 1 cycle later (LOAD_FIRST_DATA).
//    First payload write in the following cycle.
//  - Unused/illegal state encodings -> DECODE_ADDRESS next cycle.
//  - resetn low mid-packet: immediate return to reset state; partial packet abandoned.
// TESTING
//  1. Reset, then pkt_valid=1 with addr=1 and fifo_empty=3'b111.
//     -> State sequence DA, LFD, LD.
//     -> busy=1 only in the LFD cycle; dest_addr=1.
//  2. 3-byte payload, pkt_valid falls after last byte.
//     -> LD x3, LP, CPE, DA.
//     -> write_enb_reg=1 for 4 cycles (3 payload + parity); rst_int_reg pulses 1 cycle.
//  3. fifo_full=1 during LD for 4 cycles.
//     -> FFS held 4 cycles with busy=1 and write_enb_reg=0.
//     -> Then LAF, then LD (low_pkt_valid=0, parity_done=0).
//  4. Header addr=2 with fifo_empty[2]=0 for 5 cycles.
//     -> WTE for 5 cycles with busy=1.
//     -> LFD the cycle after fifo_empty[2] rises.
//  5. Header addr=3.
//     -> Remains DA; no lfd/ld/write_enb_reg; dest_addr unchanged.
//  6. soft_reset[dest_addr]=1 mid-LD.
//     -> DA next cycle.
//     -> soft_reset on a non-selected port has no effect.
//     -> resetn=0 mid-FFS restores reset outputs.

Source files
------------

// File: rtl/router_ctrl_fsm.sv
// Packet-sequencing controller for the 1x3 router: Moore FSM that sequences
// header/payload/parity loading into the destination FIFOs and stalls the source.
module router_ctrl_fsm #(
   parameter int NUM_DEST = 3,
   parameter int ADDR_W   = 2
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                pkt_valid,
   input  logic [ADDR_W-1:0]   data_in,
   input  logic                fifo_full,
   input  logic [NUM_DEST-1:0] fifo_empty,
   input  logic [NUM_DEST-1:0] soft_reset,
   input  logic                parity_done,
   input  logic                low_pkt_valid,
   output logic [ADDR_W-1:0]   dest_addr,
   output logic                detect_add,
   output logic                lfd_state,
   output logic                ld_state,
   output logic                laf_state,
   output logic                full_state,
   output logic                rst_int_reg,
   output logic                write_enb_reg,
   output logic                busy
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_DEST);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
   logic              addr_valid_s;
   logic              hdr_empty_s;
   logic              sel_empty_s;
   logic              sel_srst_s;

   // Bounds-safe per-destination bit select; addresses past NUM_DEST read as 0.
   function automatic logic sel_bit(input logic [NUM_DEST-1:0] vec,
                                    input logic [ADDR_W-1:0]   addr);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_DEST; i++) begin
         if (addr == ADDR_W'(i)) begin
            r = vec[i];
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   assign addr_valid_s = ({1'b0, data_in} < ADDR_LIMIT);
   assign hdr_empty_s  = sel_bit(fifo_empty, data_in);
   assign sel_empty_s  = sel_bit(fifo_empty, dest_addr_q);
   assign sel_srst_s   = sel_bit(soft_reset, dest_addr_q);

   // State and latched destination registers
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= DECODE_ADDRESS;
         dest_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         dest_addr_q <= dest_addr_d;
      end
   end

   // Next-state and destination-latch logic; soft reset of the selected port wins
   always_comb begin
      state_d     = state_q;
      dest_addr_d = dest_addr_q;
      if ((state_q == DECODE_ADDRESS) && pkt_valid && addr_valid_s) begin
         dest_addr_d = data_in;
      end else begin
         dest_addr_d = dest_addr_q;
      end
      if ((state_q != DECODE_ADDRESS) && sel_srst_s) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (pkt_valid && addr_valid_s) begin
                  state_d = hdr_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end else begin
                  state_d = DECODE_ADDRESS;
               end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full) begin
                  state_d = FIFO_FULL_STATE;
               end else if (!pkt_valid) begin
                  state_d = LOAD_PARITY;
               end else begin
                  state_d = LOAD_DATA;
               end
            end
            FIFO_FULL_STATE: state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
               if (parity_done) begin
                  state_d = DECODE_ADDRESS;
               end else if (low_pkt_valid) begin
                  state_d = LOAD_PARITY;
               end else begin
                  state_d = LOAD_DATA;
               end
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    state_d = sel_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default:            state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // Moore output decode of the current state
   always_comb begin
      detect_add    = 1'b0;
      lfd_state     = 1'b0;
      ld_state      = 1'b0;
      laf_state     = 1'b0;
      full_state    = 1'b0;
      rst_int_reg   = 1'b0;
      write_enb_reg = 1'b0;
      busy          = 1'b0;
      case (state_q)
         DECODE_ADDRESS:  detect_add = 1'b1;
         LOAD_FIRST_DATA: begin
            lfd_state = 1'b1;
            busy      = 1'b1;
         end
         LOAD_DATA: begin
            ld_state      = 1'b1;
            write_enb_reg = 1'b1;
         end
         FIFO_FULL_STATE: begin
            full_state = 1'b1;
            busy       = 1'b1;
         end
         LOAD_AFTER_FULL: begin
            laf_state     = 1'b1;
            write_enb_reg = 1'b1;
            busy          = 1'b1;
         end
         LOAD_PARITY: begin
            write_enb_reg = 1'b1;
            busy          = 1'b1;
         end
         CHECK_PARITY_ERROR: begin
            rst_int_reg = 1'b1;
            busy        = 1'b1;
         end
         WAIT_TILL_EMPTY: busy = 1'b1;
         default:         detect_add = 1'b1;
      endcase
   end

   assign dest_addr = dest_addr_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: per-scenario stimulus tables whose
// expected output words go through a scoreboard queue and are checked after each edge.
module tb_router_ctrl_fsm;

   logic       clock;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] soft_reset;
   logic       parity_done;
   logic       low_pkt_valid;
   logic [1:0] dest_addr;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       rst_int_reg, write_enb_reg, busy;

   int ntests = 0;
   int nfail  = 0;

   // Output word order: detect_add lfd ld laf full rst_int write_enb busy
   localparam logic [7:0] E_DA  = 8'b1000_0000;
   localparam logic [7:0] E_LFD = 8'b0100_0001;
   localparam logic [7:0] E_LD  = 8'b0010_0010;
   localparam logic [7:0] E_LAF = 8'b0001_0011;
   localparam logic [7:0] E_FFS = 8'b0000_1001;
   localparam logic [7:0] E_LP  = 8'b0000_0011;
   localparam logic [7:0] E_CPE = 8'b0000_0101;
   localparam logic [7:0] E_WTE = 8'b0000_0001;

   typedef struct packed {
      logic       rn;
      logic       pv;
      logic [1:0] din;
      logic       ff;
      logic [2:0] fe;
      logic [2:0] sr;
      logic       pd;
      logic       lpv;
      logic [9:0] exp;
   } step_t;

   logic [9:0] sb[$];

   router_ctrl_fsm #(.NUM_DEST(3), .ADDR_W(2)) dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .dest_addr(dest_addr), .detect_add(detect_add), .lfd_state(lfd_state),
      .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic step_t mk(input logic rn, input logic pv, input logic [1:0] din,
                                input logic ff, input logic [2:0] fe, input logic [2:0] sr,
                                input logic pd, input logic lpv,
                                input logic [1:0] da, input logic [7:0] code);
      step_t s;
      s.rn = rn; s.pv = pv; s.din = din; s.ff = ff; s.fe = fe; s.sr = sr;
      s.pd = pd; s.lpv = lpv; s.exp = {da, code};
      return s;
   endfunction

   function automatic logic [9:0] obs();
      return {dest_addr, detect_add, lfd_state, ld_state, laf_state, full_state,
              rst_int_reg, write_enb_reg, busy};
   endfunction

   task automatic apply(input step_t s);
      resetn = s.rn; pkt_valid = s.pv; data_in = s.din; fifo_full = s.ff;
      fifo_empty = s.fe; soft_reset = s.sr; parity_done = s.pd; low_pkt_valid = s.lpv;
      sb.push_back(s.exp);
   endtask

   task automatic test_reset();
      step_t s[$];
      logic [9:0] e, g;
      s.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_DA));
      s.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_DA));
      foreach (s[i]) begin
         apply(s[i]);
         @(posedge clock); #1;
         g = obs(); e = sb.pop_front(); ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL reset step %0d: got %b expected %b", i, g, e);
         end
      end
   endtask

   task automatic test_basic_packet();
      step_t s[$];
      logic [9:0] e, g;
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_LFD));
      for (int k = 0; k < 3; k++)
         s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_LD));
      s.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_LP));
      s.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_CPE));
      s.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_DA));
      foreach (s[i]) begin
         apply(s[i]);
         @(posedge clock); #1;
         g = obs(); e = sb.pop_front(); ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL basic_packet step %0d: got %b expected %b", i, g, e);
         end
      end
   endtask

   task automatic test_fifo_full();
      step_t s[$];
      logic [9:0] e, g;
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LFD));
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LD));
      for (int k = 0; k < 4; k++)
         s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_FFS));
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LAF));
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LD));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LP));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_CPE));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_DA));
      foreach (s[i]) begin
         apply(s[i]);
         @(posedge clock); #1;
         g = obs(); e = sb.pop_front(); ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL fifo_full step %0d: got %b expected %b", i, g, e);
         end
      end
   endtask

   task automatic test_wait_empty();
      step_t s[$];
      logic [9:0] e, g;
      for (int k = 0; k < 5; k++)
         s.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 2'd2, E_WTE));
      s.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_LFD));
      s.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_LD));
      s.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_LP));
      s.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_CPE));
      s.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_DA));
      foreach (s[i]) begin
         apply(s[i]);
         @(posedge clock); #1;
         g = obs(); e = sb.pop_front(); ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL wait_empty step %0d: got %b expected %b", i, g, e);
         end
      end
   endtask

   task automatic test_invalid_addr();
      step_t s[$];
      logic [9:0] e, g;
      for (int k = 0; k < 3; k++)
         s.push_back(mk(1'b1, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_DA));
      foreach (s[i]) begin
         apply(s[i]);
         @(posedge clock); #1;
         g = obs(); e = sb.pop_front(); ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL invalid_addr step %0d: got %b expected %b", i, g, e);
         end
      end
   endtask

   task automatic test_soft_reset();
      step_t s[$];
      logic [9:0] e, g;
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_LFD));
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_LD));
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b101, 1'b0, 1'b0, 2'd1, E_LD));
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, 2'd1, E_DA));
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, 2'd1, E_LFD));
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_LD));
      s.push_back(mk(1'b1, 1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd1, E_FFS));
      s.push_back(mk(1'b0, 1'b1, 2'd1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_DA));
      s.push_back(mk(1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_DA));
      foreach (s[i]) begin
         apply(s[i]);
         @(posedge clock); #1;
         g = obs(); e = sb.pop_front(); ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL soft_reset step %0d: got %b expected %b", i, g, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      logic [9:0] e, g;
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LFD));
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LD));
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_FFS));
      s.push_back(mk(1'b1, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 2'd0, E_LAF));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 2'd0, E_LP));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_CPE));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_FFS));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd0, E_LAF));
      s.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 2'd0, E_DA));
      s.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_LFD));
      s.push_back(mk(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_LD));
      s.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_LP));
      s.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_CPE));
      s.push_back(mk(1'b1, 1'b0, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 2'd2, E_DA));
      foreach (s[i]) begin
         apply(s[i]);
         @(posedge clock); #1;
         g = obs(); e = sb.pop_front(); ntests++;
         if (g !== e) begin
            nfail++;
            $display("FAIL back_to_back step %0d: got %b expected %b", i, g, e);
         end
      end
   endtask

   initial begin
      resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
      fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
      test_reset();
      test_basic_packet();
      test_fifo_full();
      test_wait_empty();
      test_invalid_addr();
      test_soft_reset();
      test_back_to_back();
      ntests++;
      if (sb.size() != 0) begin
         nfail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
